download_buffer: RTL



---
 rtl/download_buffer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/download_buffer.sv
// Elastic FIFO between the HPS ioctl download port and Main's download port.
// Replays queued {addr, data} words under waitReq backpressure and throttles the HPS via ioctl_wait.
module download_buffer #(
  parameter int DEPTH  = 8,
  parameter int SLACK  = 2,
  parameter int ADDR_W = 25,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [DATA_W-1:0] ioctl_dout,
  output logic              ioctl_wait,
  output logic              dl_cs,
  output logic              dl_wr,
  output logic [ADDR_W-1:0] dl_addr,
  output logic [DATA_W-1:0] dl_dout,
  input  logic              dl_waitReq,
  output logic              overflow,
  output logic [23:0]       words_done
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ADDR_W + DATA_W;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] WAIT_TH  = CW'(DEPTH - SLACK);

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

  state_t            state_q;
  logic [EW-1:0]     mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              dl_cs_q, overflow_q, wait_q;
  logic [23:0]       words_done_q;
  logic              push, pop, full, push_ok, drop;
  logic [EW-1:0]     head;

  always_comb begin
    push     = ioctl_wr & ioctl_download;
    pop      = dl_wr & ~dl_waitReq;
    full     = (count_q == FULL_CNT);
    // At full, a same-cycle pop frees the slot so the push is still accepted.
    push_ok  = push & (~full | pop);
    drop     = push & full & ~pop;
    wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  assign dl_wr      = (count_q != '0);
  assign head       = mem_q[rd_ptr_q];
  // Storage is not reset; mask the head so an empty FIFO presents zeros.
  assign dl_addr    = dl_wr ? head[EW-1:DATA_W] : '0;
  assign dl_dout    = dl_wr ? head[DATA_W-1:0] : '0;
  assign dl_cs      = dl_cs_q;
  assign overflow   = overflow_q;
  assign ioctl_wait = wait_q;
  assign words_done = words_done_q;

  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= {ioctl_addr, ioctl_dout};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      dl_cs_q      <= 1'b0;
      overflow_q   <= 1'b0;
      wait_q       <= 1'b0;
      words_done_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wait_q   <= (count_d >= WAIT_TH);
      if (drop) overflow_q <= 1'b1;
      if (pop && (words_done_q != '1)) words_done_q <= words_done_q + 24'd1;
      case (state_q)
        IDLE: begin
          if (ioctl_download) begin
            state_q      <= ACTIVE;
            dl_cs_q      <= 1'b1;
            overflow_q   <= 1'b0;
            words_done_q <= '0;
          end
        end
        ACTIVE: begin
          if (!ioctl_download) begin
            if (count_q == '0) begin
              state_q <= IDLE;
              dl_cs_q <= 1'b0;
            end else begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // A re-raised download resumes the current one without clearing stats.
          if (ioctl_download) begin
            state_q <= ACTIVE;
          end else if (count_d == '0) begin
            state_q <= IDLE;
            dl_cs_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          dl_cs_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
